// File: rtl/proc_mem_arbiter.sv
// Serializes TinyRV1 instruction fetch and data access onto one single-ported memory.
// A FETCH phase loads the instruction buffer; an EXEC phase replays it while the data port uses memory.
module proc_mem_arbiter #(
    parameter logic [31:0] p_reset_inst = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_val,
    input  logic [31:0] imem_addr,
    output logic        imem_wait,
    output logic [31:0] imem_rdata,
    input  logic        dmem_val,
    input  logic        dmem_type,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_wait,
    output logic [31:0] dmem_rdata,
    output logic        mem_val,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_wait
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    always_comb begin
        state_d    = state_q;
        inst_buf_d = inst_buf_q;
        mem_val    = 1'b0;
        mem_type   = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        imem_wait  = 1'b1;
        imem_rdata = 32'h0;
        dmem_wait  = 1'b1;
        dmem_rdata = 32'h0;
        // Reset forces every output idle so a pending store can never complete.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_val  = imem_val;
                    mem_addr = imem_addr;
                    if (imem_val && !mem_wait) begin
                        inst_buf_d = mem_rdata;
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    imem_wait  = 1'b0;
                    imem_rdata = inst_buf_q;
                    dmem_rdata = mem_rdata;
                    if (dmem_val) begin
                        mem_val   = 1'b1;
                        mem_type  = dmem_type;
                        mem_addr  = dmem_addr;
                        mem_wdata = dmem_wdata;
                        dmem_wait = mem_wait;
                        if (!mem_wait) begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        dmem_wait = 1'b0;
                        state_d   = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            inst_buf_q <= p_reset_inst;
        end else begin
            state_q    <= state_d;
            inst_buf_q <= inst_buf_d;
        end
    end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Bench for proc_mem_arbiter: directed vector table followed by random traffic vs. a phase model.
module tb_proc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_val = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        dmem_val = 1'b0;
    logic        dmem_type = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        dmem_wait;
    logic [31:0] dmem_rdata;
    logic        mem_val;
    logic        mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_wait = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .imem_val(imem_val), .imem_addr(imem_addr), .imem_wait(imem_wait), .imem_rdata(imem_rdata),
        .dmem_val(dmem_val), .dmem_type(dmem_type), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata),
        .mem_val(mem_val), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dt;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic        mw;
    } in_t;

    typedef struct {
        logic        mv;
        logic        mt;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        iw;
        logic [31:0] ird;
        logic        dw;
        logic [31:0] drd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [31:0] ia, input logic dv,
                       input logic dt, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [31:0] mrd, input logic mw,
                       input logic mv, input logic mt, input logic [31:0] ma, input logic [31:0] mwd,
                       input logic iw, input logic [31:0] ird, input logic dw, input logic [31:0] drd);
        vec_t v;
        v.i = '{r, iv, ia, dv, dt, da, dwd, mrd, mw};
        v.o = '{mv, mt, ma, mwd, iw, ird, dw, drd};
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst        = i.rst;
        imem_val   = i.iv;
        imem_addr  = i.ia;
        dmem_val   = i.dv;
        dmem_type  = i.dt;
        dmem_addr  = i.da;
        dmem_wdata = i.dwd;
        mem_rdata  = i.mrd;
        mem_wait   = i.mw;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input out_t e);
        chk("mem_val",    idx, {31'h0, mem_val},   {31'h0, e.mv});
        chk("mem_type",   idx, {31'h0, mem_type},  {31'h0, e.mt});
        chk("mem_addr",   idx, mem_addr,           e.ma);
        chk("mem_wdata",  idx, mem_wdata,          e.mwd);
        chk("imem_wait",  idx, {31'h0, imem_wait}, {31'h0, e.iw});
        chk("imem_rdata", idx, imem_rdata,         e.ird);
        chk("dmem_wait",  idx, {31'h0, dmem_wait}, {31'h0, e.dw});
        chk("dmem_rdata", idx, dmem_rdata,         e.drd);
    endtask

    // Reference: an instruction is "being fetched" or "being executed"; outputs follow from that.
    bit          executing = 1'b0;
    logic [31:0] held_inst = 32'h00000013;

    function automatic out_t model_out(input in_t i);
        out_t o;
        o = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0};
        if (i.rst) return o;
        if (!executing) begin
            o.mv = i.iv;
            o.ma = i.ia;
        end else begin
            o.iw  = 1'b0;
            o.ird = held_inst;
            o.drd = i.mrd;
            if (i.dv) begin
                o.mv  = 1'b1;
                o.mt  = i.dt;
                o.ma  = i.da;
                o.mwd = i.dwd;
                o.dw  = i.mw;
            end else begin
                o.dw = 1'b0;
            end
        end
        return o;
    endfunction

    task automatic model_step(input in_t i);
        if (i.rst) begin
            executing = 1'b0;
            held_inst = 32'h00000013;
        end else if (!executing) begin
            if (i.iv && !i.mw) begin
                held_inst = i.mrd;
                executing = 1'b1;
            end
        end else if (!(i.dv && i.mw)) begin
            executing = 1'b0;
        end
    endtask

    initial begin
        in_t ri;
        // Reset held three cycles with garbage on the memory read bus
        for (int k = 0; k < 3; k++)
            add(1, 1, 32'h200, 0, 0, 0, 0, 32'hDEADBEEF, 0,  0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 32'h200, 0, 0, 0, 0, 32'hDEADBEEF, 0,  0, 0, 32'h200, 0, 1, 0, 1, 0);
        // addi at 0x200, zero wait
        add(0, 1, 32'h200, 0, 0, 0, 0, 32'h00108093, 0,  1, 0, 32'h200, 0, 1, 0, 1, 0);
        add(0, 0, 32'h200, 0, 0, 0, 0, 32'h00005555, 0,  0, 0, 0, 0, 0, 32'h00108093, 0, 32'h00005555);
        // fetch with 3 wait cycles; dmem request during FETCH is ignored
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'h204, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0000AAAA, 1,  1, 0, 32'h204, 0, 1, 0, 1, 0);
        add(0, 1, 32'h204, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h00002083, 0,  1, 0, 32'h204, 0, 1, 0, 1, 0);
        // lw with two data wait cycles
        for (int k = 0; k < 2; k++)
            add(0, 1, 32'h204, 1, 0, 32'h1000, 0, 32'h0, 1,  1, 0, 32'h1000, 0, 0, 32'h00002083, 1, 0);
        add(0, 1, 32'h204, 1, 0, 32'h1000, 0, 32'h12345678, 0,  1, 0, 32'h1000, 0, 0, 32'h00002083, 0, 32'h12345678);
        // sw zero wait, then the store must not persist into the next FETCH
        add(0, 1, 32'h208, 0, 0, 0, 0, 32'h0020A223, 0,  1, 0, 32'h208, 0, 1, 0, 1, 0);
        add(0, 1, 32'h208, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0, 0,  1, 1, 32'h1004, 32'hCAFEF00D, 0, 32'h0020A223, 0, 0);
        add(0, 1, 32'h20C, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0020A223, 0,  1, 0, 32'h20C, 0, 1, 0, 1, 0);
        // stalled sw interrupted by reset
        add(0, 1, 32'h20C, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0, 1,  1, 1, 32'h1004, 32'hCAFEF00D, 0, 32'h0020A223, 1, 0);
        add(1, 1, 32'h20C, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0, 1,  0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 32'h210, 1, 1, 32'h1004, 32'hCAFEF00D, 32'h0, 0,  0, 0, 32'h210, 0, 1, 0, 1, 0);
        add(0, 1, 32'h210, 0, 0, 0, 0, 32'h00000013, 0,  1, 0, 32'h210, 0, 1, 0, 1, 0);
        add(0, 0, 32'h210, 0, 0, 0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 32'h00000013, 0, 0);

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].i);
            #1;
            check_all(n, vecs[n].o);
            @(posedge clk);
        end

        // Random traffic, starting from reset so model and DUT agree
        ri = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n > 0) begin
                ri.rst = ($urandom_range(0, 39) == 0);
                ri.iv  = ($urandom_range(0, 3) != 0);
                ri.ia  = $urandom & 32'hFFFF_FFFC;
                ri.dv  = $urandom_range(0, 1);
                ri.dt  = $urandom_range(0, 1);
                ri.da  = $urandom;
                ri.dwd = $urandom;
                ri.mrd = $urandom;
                ri.mw  = ($urandom_range(0, 2) == 0);
            end
            drive(ri);
            #1;
            check_all(1000 + n, model_out(ri));
            @(posedge clk);
            model_step(ri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
# proc_mem_arbiter

Shares one single-ported memory between the instruction-fetch port and the data port of the single-cycle TinyRV1 processor. Each instruction is serialized into a FETCH phase and an EXEC phase. The fetched word is buffered and replayed to the processor while the data access, if any, uses the memory. The block sits between the processor's imem/dmem val/wait interfaces and the shared memory's val/wait interface.

## Interface
- p_reset_inst, 32'h00000013, value loaded into the instruction buffer on reset (addi x0,x0,0)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_val  input  1  fetch request
- imem_addr  input  32  fetch address; requester holds it stable until retire
- imem_wait  output  1  fetch not yet available
- imem_rdata  output  32  instruction word, valid when imem_val && !imem_wait
- dmem_val  input  1  data request
- dmem_type  input  1  0 = read (rd), 1 = write (wr)
- dmem_addr  input  32  data address
- dmem_wdata  input  32  store data
- dmem_wait  output  1  data access not yet complete
- dmem_rdata  output  32  load data, valid when dmem_val && !dmem_wait
- mem_val  output  1  shared-memory request
- mem_type  output  1  0 = read, 1 = write
- mem_addr  output  32  shared-memory address
- mem_wdata  output  32  shared-memory store data
- mem_rdata  input  32  read data, combinationally valid in the completing cycle
- mem_wait  input  1  memory not complete; the request completes in the cycle mem_val && !mem_wait

## Operation
- State register has two states: FETCH and EXEC. Reset and power-on state is FETCH. inst_buf (32b) resets to p_reset_inst.
- FETCH:
  - mem_val=imem_val, mem_type=0, mem_addr=imem_addr, mem_wdata=0.
  - imem_wait=1 and dmem_wait=1 unconditionally. dmem requests are ignored; nothing is forwarded.
  - If imem_val && !mem_wait: inst_buf <= mem_rdata and the next state is EXEC. Otherwise the state stays FETCH.
- EXEC:
  - imem_wait=0 and imem_rdata=inst_buf. The processor decodes from the buffered word.
  - If dmem_val: mem_val=1, mem_type=dmem_type, mem_addr=dmem_addr, mem_wdata=dmem_wdata, and dmem_wait=mem_wait.
    - If !mem_wait, the access completes and the next state is FETCH.
    - Otherwise the state stays EXEC, dmem_wait stays 1, and the request is reissued.
  - If !dmem_val: mem_val=0 and dmem_wait=0. The instruction retires this cycle and the next state is FETCH.
- dmem_rdata=mem_rdata in EXEC and 0 in FETCH. imem_rdata=0 in FETCH.
- Retire condition, which the processor uses as pc_en: state==EXEC && !(dmem_val && mem_wait).
- No output may depend combinationally on imem_val or dmem_val in a way that feeds back into imem_wait. imem_wait is a pure function of state and rst.

## Timing
- While rst=1: mem_val=0, mem_type=0, mem_addr=0, mem_wdata=0, imem_wait=1, dmem_wait=1, imem_rdata=0, dmem_rdata=0.
- On the first edge after rst falls, the block is in FETCH with inst_buf=p_reset_inst.
- Latency with zero memory wait:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - lw/sw: 2 cycles. The data access happens in the EXEC cycle.
- With mem_wait stretches: cycles per instruction = 2 + (fetch wait cycles) + (data wait cycles).
- Reset asserted mid-FETCH or mid-EXEC: mem_val drops in the same cycle. On the next edge the state is FETCH and inst_buf=p_reset_inst. A pending store is abandoned and memory sees no completed write.
- Ownership of the memory port changes only on a state transition, never mid-request. mem_addr/mem_type/mem_wdata stay stable while mem_wait=1, provided the requester holds its inputs.
- imem_val=0 in FETCH: no memory request and the state holds. No spurious inst_buf update.
- dmem_val rising in the same EXEC cycle that the state is entered is legal and is the normal case.

## Test plan
- Reset: hold rst 3 cycles with mem_rdata=32'hDEADBEEF, then release. Required: all outputs at their reset values during reset, state FETCH after release, and imem_rdata=32'h00000013 once EXEC is first entered with an empty fetch.
- addi at 0x200, zero wait: mem_rdata=32'h00108093 in the FETCH cycle. Required: mem_val=1, mem_addr=0x200, imem_wait=1; next cycle imem_wait=0, imem_rdata=32'h00108093, mem_val=0, dmem_wait=0; the next fetch starts on the cycle after.
- lw with 2 data wait cycles: in EXEC, dmem_val=1, type=0, addr=0x1000, mem_wait=1,1,0, mem_rdata=32'h12345678 on the last cycle. Required: dmem_wait=1,1,0, mem_addr=0x1000 held for 3 cycles, dmem_rdata=32'h12345678 in the final cycle, and FETCH on the following edge.
- sw: dmem_type=1, addr=0x1004, wdata=32'hCAFEF00D, zero wait. Required: mem_type=1, mem_wdata=32'hCAFEF00D for exactly one cycle, and imem_rdata still equals the buffered sw word.
- Fetch wait 3 cycles: mem_wait=1,1,1,0 in FETCH. Required: imem_wait=1 for all 4 cycles, inst_buf captured only on the 4th, and a dmem_val=1 asserted during FETCH produces no memory request.
- Reset mid-store: assert rst in EXEC while a sw has mem_wait=1. Required: mem_val=0 in that cycle, FETCH next, inst_buf=32'h00000013.
